cti_flow_ctrl: RTL and testbench

Control-transfer sequencer for the fetch stage and PC register. It watches the decode-stage opcode for JAL (7'b1101111), JALR (7'b1100111) and BRANCH (7'b1100011). On detection it freezes the PC and bubbles decode until execute resolves the transfer. It then either releases sequential fetch or redirects the PC to the resolved target and flushes the wrong-path instruction. It also keeps saturating counts of control transfers and taken redirects, plus a sticky resolve-timeout error.

---
 rtl/cti_pkg.sv | 15 +
 rtl/sat_counter.sv | 19 +
 rtl/cti_flow_ctrl.sv | 124 ++++++++++++
 tb/tb_cti_flow_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cti_pkg.sv
// Shared opcodes, state/class encodings and PC select constants for the
// control-transfer sequencer.
package cti_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {RUN, WAIT, REDIRECT} state_t;
  typedef enum logic [1:0] {BR, JAL, JALR} cti_cls_t;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_TGT = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cti_flow_ctrl.sv
// Fetch/PC sequencer: holds the PC while a jump or branch resolves in execute,
// then either resumes sequential fetch or redirects and flushes fetch.
module cti_flow_ctrl
  import cti_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             valid_d,
  input  logic [6:0]       op_d,
  input  logic             ext_stall,
  input  logic             resolve_valid_x,
  input  logic             b_taken_x,
  input  logic [31:0]      target_x,
  output logic             pc_en,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic             bubble_d,
  output logic             flush_f,
  output logic             busy,
  output logic             resolve_err,
  output logic [CNT_W-1:0] cti_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  state_t         state;
  cti_cls_t       cls;
  cti_cls_t       op_cls;
  logic [WCW-1:0] wait_cnt;
  logic           is_cti;
  logic           cti_inc;
  logic           taken_inc;

  always_comb begin
    is_cti = 1'b0;
    op_cls = BR;
    case (op_d)
      OP_JAL:    begin is_cti = valid_d; op_cls = JAL;  end
      OP_JALR:   begin is_cti = valid_d; op_cls = JALR; end
      OP_BRANCH: begin is_cti = valid_d; op_cls = BR;   end
      default:   ;
    endcase
  end

  assign cti_inc   = !RESET && !ext_stall && (state == RUN) && is_cti;
  assign taken_inc = !RESET && !ext_stall && (state == REDIRECT);

  // A resolve in the last permitted WAIT cycle takes priority over the timeout.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= RUN;
      cls         <= BR;
      wait_cnt    <= '0;
      pc_target   <= '0;
      resolve_err <= 1'b0;
    end else if (!ext_stall) begin
      case (state)
        RUN: begin
          if (is_cti) begin
            state    <= WAIT;
            cls      <= op_cls;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + WCW'(1);
          if (resolve_valid_x) begin
            pc_target <= target_x;
            state     <= (b_taken_x || (cls != BR)) ? REDIRECT : RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            resolve_err <= 1'b1;
            state       <= RUN;
          end
        end
        REDIRECT: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  always_comb begin
    pc_en    = 1'b0;
    pc_sel   = PC_SEL_SEQ;
    bubble_d = 1'b0;
    flush_f  = 1'b0;
    busy     = 1'b0;
    if (!RESET) begin
      busy = (state != RUN);
      if (state == REDIRECT) pc_sel = PC_SEL_TGT;
      if (!ext_stall) begin
        case (state)
          RUN:      pc_en = 1'b1;
          WAIT:     bubble_d = 1'b1;
          REDIRECT: begin
            pc_en    = 1'b1;
            flush_f  = 1'b1;
            bubble_d = 1'b1;
          end
          default:  ;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cti_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (cti_inc),
    .count (cti_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (taken_inc),
    .count (taken_cnt)
  );

endmodule

// File: tb/tb_cti_flow_ctrl.sv
// Scoreboard bench: two sequencer instances (default and small timeout/counter
// widths) share randomized inputs and are checked against a transfer-level model.
module tb_cti_flow_ctrl;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, valid_d, ext_stall, resolve_valid_x, b_taken_x;
  logic [6:0]  op_d;
  logic [31:0] target_x;

  logic        a_pc_en, a_pc_sel, a_bubble_d, a_flush_f, a_busy, a_err;
  logic [31:0] a_pc_target;
  logic [15:0] a_cti_cnt, a_taken_cnt;
  logic        b_pc_en, b_pc_sel, b_bubble_d, b_flush_f, b_busy, b_err;
  logic [31:0] b_pc_target;
  logic [1:0]  b_cti_cnt, b_taken_cnt;

  cti_flow_ctrl #(.MAX_WAIT(4), .CNT_W(16)) dut_a (
    .CLK(clk), .RESET(reset), .valid_d(valid_d), .op_d(op_d), .ext_stall(ext_stall),
    .resolve_valid_x(resolve_valid_x), .b_taken_x(b_taken_x), .target_x(target_x),
    .pc_en(a_pc_en), .pc_sel(a_pc_sel), .pc_target(a_pc_target), .bubble_d(a_bubble_d),
    .flush_f(a_flush_f), .busy(a_busy), .resolve_err(a_err),
    .cti_cnt(a_cti_cnt), .taken_cnt(a_taken_cnt)
  );

  cti_flow_ctrl #(.MAX_WAIT(2), .CNT_W(2)) dut_b (
    .CLK(clk), .RESET(reset), .valid_d(valid_d), .op_d(op_d), .ext_stall(ext_stall),
    .resolve_valid_x(resolve_valid_x), .b_taken_x(b_taken_x), .target_x(target_x),
    .pc_en(b_pc_en), .pc_sel(b_pc_sel), .pc_target(b_pc_target), .bubble_d(b_bubble_d),
    .flush_f(b_flush_f), .busy(b_busy), .resolve_err(b_err),
    .cti_cnt(b_cti_cnt), .taken_cnt(b_taken_cnt)
  );

  // ctrl bits: {pc_en, pc_sel, bubble_d, flush_f, busy}
  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] tgt;
    logic        err;
    int          cti;
    int          taken;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad   = 0;

  int          mw[2]   = '{4, 2};
  int          cmax[2] = '{65535, 3};
  bit          m_flight[2], m_jump[2], m_redir[2], m_err[2];
  int          m_waited[2], m_cti[2], m_taken[2];
  logic [31:0] m_tgt[2];

  function automatic exp_t predict(int i);
    exp_t e;
    bit   in_xfer;
    in_xfer = m_flight[i] || m_redir[i];
    e.ctrl  = '0;
    if (!reset) begin
      e.ctrl[0] = in_xfer;
      e.ctrl[3] = m_redir[i];
      if (!ext_stall) begin
        e.ctrl[4] = !m_flight[i];
        e.ctrl[2] = in_xfer;
        e.ctrl[1] = m_redir[i];
      end
    end
    e.tgt   = m_tgt[i];
    e.err   = m_err[i];
    e.cti   = m_cti[i];
    e.taken = m_taken[i];
    return e;
  endfunction

  function automatic void advance(int i);
    if (reset) begin
      m_flight[i] = 0; m_redir[i] = 0; m_jump[i] = 0; m_err[i] = 0;
      m_waited[i] = 0; m_cti[i] = 0; m_taken[i] = 0; m_tgt[i] = '0;
    end else if (!ext_stall) begin
      if (m_redir[i]) begin
        m_redir[i] = 0;
        if (m_taken[i] < cmax[i]) m_taken[i]++;
      end else if (m_flight[i]) begin
        if (resolve_valid_x) begin
          m_tgt[i]    = target_x;
          m_flight[i] = 0;
          m_redir[i]  = b_taken_x || m_jump[i];
        end else if (m_waited[i] + 1 >= mw[i]) begin
          m_err[i]    = 1;
          m_flight[i] = 0;
        end
        m_waited[i]++;
      end else if (valid_d && (op_d == OPC_JAL || op_d == OPC_JALR || op_d == OPC_BR)) begin
        m_flight[i] = 1;
        m_jump[i]   = (op_d != OPC_BR);
        m_waited[i] = 0;
        if (m_cti[i] < cmax[i]) m_cti[i]++;
      end
    end
  endfunction

  task automatic applyStimulus(input logic r, input logic v, input logic [6:0] op,
                               input logic s, input logic rv, input logic bt,
                               input logic [31:0] tg);
    @(posedge clk);
    #1;
    reset = r; valid_d = v; op_d = op; ext_stall = s;
    resolve_valid_x = rv; b_taken_x = bt; target_x = tg;
    q_a.push_back(predict(0));
    q_b.push_back(predict(1));
    advance(0);
    advance(1);
  endtask

  task automatic checkOutput(input string name, input int cyc,
                             input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  int mon_cyc = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        exp_t e;
        e = q_a.pop_front();
        checkOutput("a_ctrl", mon_cyc, {59'd0, a_pc_en, a_pc_sel, a_bubble_d, a_flush_f, a_busy}, {59'd0, e.ctrl});
        checkOutput("a_target", mon_cyc, {32'd0, a_pc_target}, {32'd0, e.tgt});
        checkOutput("a_err", mon_cyc, {63'd0, a_err}, {63'd0, e.err});
        checkOutput("a_cnts", mon_cyc, {32'd0, a_cti_cnt, a_taken_cnt}, {32'd0, e.cti[15:0], e.taken[15:0]});
      end
      if (q_b.size() > 0) begin
        exp_t e;
        e = q_b.pop_front();
        checkOutput("b_ctrl", mon_cyc, {59'd0, b_pc_en, b_pc_sel, b_bubble_d, b_flush_f, b_busy}, {59'd0, e.ctrl});
        checkOutput("b_target", mon_cyc, {32'd0, b_pc_target}, {32'd0, e.tgt});
        checkOutput("b_err", mon_cyc, {63'd0, b_err}, {63'd0, e.err});
        checkOutput("b_cnts", mon_cyc, {60'd0, b_cti_cnt, b_taken_cnt}, {60'd0, e.cti[1:0], e.taken[1:0]});
      end
      mon_cyc++;
    end
  end

  initial begin
    reset = 1'b1; valid_d = 1'b0; op_d = '0; ext_stall = 1'b0;
    resolve_valid_x = 1'b0; b_taken_x = 1'b0; target_x = '0;
    for (int i = 0; i < 2; i++) begin
      m_flight[i] = 0; m_redir[i] = 0; m_jump[i] = 0; m_err[i] = 0;
      m_waited[i] = 0; m_cti[i] = 0; m_taken[i] = 0; m_tgt[i] = '0;
    end
    repeat (2) @(posedge clk);

    // directed: idle, branch not taken, JAL redirect, stall in WAIT, reset mid-WAIT, timeout
    applyStimulus(1, 0, 7'h00, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, 7'h13, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, OPC_BR, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 7'h00, 0, 1, 0, 32'hDEAD_0000);
    applyStimulus(0, 1, 7'h13, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, OPC_JAL, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 7'h00, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 7'h00, 0, 1, 0, 32'h0000_0100);
    applyStimulus(0, 1, OPC_BR, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, 7'h13, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, OPC_BR, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 7'h00, 1, 0, 0, 32'h0);
    applyStimulus(0, 0, 7'h00, 1, 1, 1, 32'hBAD0_0000);
    applyStimulus(0, 0, 7'h00, 1, 0, 0, 32'h0);
    applyStimulus(0, 0, 7'h00, 0, 1, 1, 32'h0000_2000);
    applyStimulus(0, 0, 7'h00, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, OPC_JALR, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 7'h00, 0, 1, 1, 32'h0000_3000);
    applyStimulus(0, 0, 7'h00, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, OPC_BR, 0, 0, 0, 32'h0);
    repeat (5) applyStimulus(0, 0, 7'h00, 0, 0, 0, 32'h0);
    repeat (6) begin
      applyStimulus(0, 1, OPC_JALR, 0, 0, 0, 32'h0);
      applyStimulus(0, 0, 7'h00, 0, 1, 0, 32'h0000_4000);
      applyStimulus(0, 0, 7'h00, 0, 0, 0, 32'h0);
    end

    for (int n = 0; n < NCYC; n++) begin
      logic [6:0] op;
      logic [2:0] pick;
      pick = 3'($urandom_range(0, 7));
      case (pick)
        3'd0, 3'd1: op = OPC_BR;
        3'd2:       op = OPC_JAL;
        3'd3:       op = OPC_JALR;
        default:    op = 7'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), op,
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                    1'($urandom), $urandom);
    end

    @(negedge clk);
    #1;
    checkOutput("drain", mon_cyc, 64'(q_a.size() + q_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
